// File: rtl/main_memory_responder_if.sv
// main_memory_responder_if: line-sized request/response bundle between cache controller and backing memory
interface main_memory_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_dataout;
    logic                  mem_req_rw;
    logic                  mem_req_valid;
    logic [DATA_WIDTH-1:0] mem_req_datain;
    logic                  mem_req_ready;
    modport master (
        output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
        input  mem_req_datain, mem_req_ready
    );
    modport slave (
        input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
        output mem_req_datain, mem_req_ready
    );
endinterface

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency line-store model answering cache mem_req_* requests.
// Define MEM_STATS_EN to build the saturating rd_count/wr_count counters; otherwise they read 0.
module main_memory_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int OFFSET_BITS = 4,
    parameter int DEPTH_LOG2  = 8,
    parameter int LATENCY     = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    main_memory_responder_if.slave mem,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);
    localparam int LINES = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    rw_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ready_q;
    logic [LINES-1:0]        valid_q;
    logic [DATA_WIDTH-1:0]   mem_q [LINES];
    logic                    complete;
    logic                    unused_addr;
    assign complete           = (state_q == BUSY) && (cnt_q == 8'd0);
    assign mem.mem_req_ready  = ready_q;
    assign mem.mem_req_datain = rdata_q;
    assign unused_addr        = &{1'b0, mem.mem_req_addr};
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            rdata_q <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (mem.mem_req_valid) begin
                    idx_q   <= mem.mem_req_addr[OFFSET_BITS +: DEPTH_LOG2];
                    rw_q    <= mem.mem_req_rw;
                    wdata_q <= mem.mem_req_dataout;
                    cnt_q   <= 8'(LATENCY - 1);
                    ready_q <= 1'b0;
                    state_q <= BUSY;
                end
                BUSY: if (cnt_q != 8'd0) begin
                    cnt_q <= cnt_q - 8'd1;
                end else begin
                    ready_q <= 1'b1;
                    state_q <= DONE;
                    if (rw_q) valid_q[idx_q] <= 1'b1;
                    else      rdata_q <= valid_q[idx_q] ? mem_q[idx_q] : '0;
                end
                // a request still held after completion must not be accepted twice
                DONE: if (!mem.mem_req_valid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (complete && rw_q) mem_q[idx_q] <= wdata_q;
    end
`ifdef MEM_STATS_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (complete) begin
            if (rw_q) wr_count_q <= wr_count_q + 16'(wr_count_q != 16'hFFFF);
            else      rd_count_q <= rd_count_q + 16'(rd_count_q != 16'hFFFF);
        end
    end
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: randomized self-checking bench with a line-array reference model.
module tb_main_memory_responder;
    localparam int LAT = 3;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] rd_count, wr_count;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [127:0] mline [256];
    bit           mvalid [256];
    logic [127:0] exp_dout = '0;
    int           exp_rd = 0;
    int           exp_wr = 0;

    main_memory_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

    main_memory_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(128), .OFFSET_BITS(4), .DEPTH_LOG2(8), .LATENCY(LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .mem(bus), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int line_of(input logic [31:0] a);
        return (a / 16) % 256;
    endfunction

    function automatic logic [15:0] want_rd();
`ifdef MEM_STATS_EN
        return (exp_rd > 65535) ? 16'hFFFF : 16'(exp_rd);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [15:0] want_wr();
`ifdef MEM_STATS_EN
        return (exp_wr > 65535) ? 16'hFFFF : 16'(exp_wr);
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mvalid[i] = 0;
        exp_dout = '0;
        exp_rd = 0;
        exp_wr = 0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic rw, input logic [127:0] d,
                          input int hold, input string tag);
        int low;
        int i;
        @(negedge clock);
        bus.mem_req_addr = a;
        bus.mem_req_rw = rw;
        bus.mem_req_dataout = d;
        bus.mem_req_valid = 1'b1;
        @(negedge clock);
        low = 0;
        while (bus.mem_req_ready === 1'b0 && low < 300) begin
            low++;
            bus.mem_req_addr = $urandom;
            bus.mem_req_dataout = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_req_rw = 1'($urandom);
            @(negedge clock);
        end
        i = line_of(a);
        if (rw) begin
            mline[i] = d;
            mvalid[i] = 1;
            exp_wr++;
        end else begin
            exp_dout = mvalid[i] ? mline[i] : '0;
            exp_rd++;
        end
        n_checks++;
        if (low !== LAT) begin
            n_fail++;
            $display("FAIL %s ready_low_cycles: got %0d want %0d", tag, low, LAT);
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clock);
            n_checks++;
            if (bus.mem_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s ready(h=%0d): got %b want 1", tag, h, bus.mem_req_ready);
            end
            n_checks++;
            if (bus.mem_req_datain !== exp_dout) begin
                n_fail++;
                $display("FAIL %s datain(h=%0d): got %h want %h", tag, h, bus.mem_req_datain, exp_dout);
            end
            n_checks++;
            if (rd_count !== want_rd() || wr_count !== want_wr()) begin
                n_fail++;
                $display("FAIL %s counts(h=%0d): got rd=%0d wr=%0d want rd=%0d wr=%0d",
                         tag, h, rd_count, wr_count, want_rd(), want_wr());
            end
        end
        bus.mem_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr = '0;
        bus.mem_req_rw = 1'b0;
        bus.mem_req_dataout = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.mem_req_ready !== 1'b1 || bus.mem_req_datain !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got ready=%b datain=%h want ready=1 datain=0",
                     bus.mem_req_ready, bus.mem_req_datain);
        end
        n_checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got rd=%0d wr=%0d want 0 0", rd_count, wr_count);
        end
    endtask

    task automatic test_write_read();
        do_req(32'h0000AB00, 1'b1, 128'h1122, 0, "write_ab00");
        do_req(32'h0000AB00, 1'b0, '0, 0, "read_ab00");
        do_req(32'h0000BC00, 1'b0, '0, 0, "read_unwritten_bc00");
    endtask

    task automatic test_alias();
        do_req(32'h0001AB00, 1'b1, 128'h3344, 0, "write_alias_1ab00");
        do_req(32'h0000AB00, 1'b0, '0, 0, "read_alias_ab00");
    endtask

    task automatic test_held_valid();
        do_req(32'h00000210, 1'b1, 128'hCAFE, 5, "held_write");
        do_req(32'h00000210, 1'b0, '0, 5, "held_read");
    endtask

    task automatic test_reset_busy();
        @(negedge clock);
        bus.mem_req_addr = 32'h0000CD00;
        bus.mem_req_rw = 1'b1;
        bus.mem_req_dataout = 128'h5566;
        bus.mem_req_valid = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.mem_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_before_reset: got ready=%b want 0", bus.mem_req_ready);
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.mem_req_ready !== 1'b1 || bus.mem_req_datain !== 128'h0 ||
            rd_count !== 16'd0 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got ready=%b datain=%h rd=%0d wr=%0d want 1 0 0 0",
                     bus.mem_req_ready, bus.mem_req_datain, rd_count, wr_count);
        end
        bus.mem_req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        do_req(32'h0000CD00, 1'b0, '0, 0, "read_discarded_cd00");
        do_req(32'h0000AB00, 1'b0, '0, 0, "read_cleared_ab00");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            do_req(a, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, "b2b_write");
            do_req(a, 1'b0, '0, 0, "b2b_read");
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
            a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 4) | ($urandom & 32'hF);
            do_req(a, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_held_valid();
        test_reset_busy();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
